// File: rtl/mipi_lane_deskew_if.sv
// Lane-side inputs and word-side outputs of the lane deskewer.
interface mipi_lane_deskew_if;
   logic [1:0]  I_lane_num;
   logic        I_ch0_valid;
   logic        I_ch1_valid;
   logic        I_ch2_valid;
   logic        I_ch3_valid;
   logic [7:0]  I_ch0_data;
   logic [7:0]  I_ch1_data;
   logic [7:0]  I_ch2_data;
   logic [7:0]  I_ch3_data;
   logic [3:0]  I_lane_error;
   logic        O_valid;
   logic [31:0] O_data;
   logic        O_skew_error;
   logic        O_busy;

   modport master (
      output I_lane_num, I_ch0_valid, I_ch1_valid, I_ch2_valid, I_ch3_valid,
             I_ch0_data, I_ch1_data, I_ch2_data, I_ch3_data, I_lane_error,
      input  O_valid, O_data, O_skew_error, O_busy
   );

   modport slave (
      input  I_lane_num, I_ch0_valid, I_ch1_valid, I_ch2_valid, I_ch3_valid,
             I_ch0_data, I_ch1_data, I_ch2_data, I_ch3_data, I_lane_error,
      output O_valid, O_data, O_skew_error, O_busy
   );
endinterface

// File: rtl/mipi_lane_deskew.sv
// Realigns up to four MIPI data lanes into 32-bit words using one byte FIFO per lane.
// state    | meaning
// IDLE     | no packet in flight; lane count sampled here
// WAIT_ALL | first bytes buffered, waiting for every active lane to hold data
// STREAM   | one aligned rank popped per cycle while all active lanes hold data
// ERROR    | one-cycle skew error pulse, FIFOs flushed
// DRAIN    | input discarded until all active lanes go quiet
module mipi_lane_deskew #(
   parameter int FIFO_DEPTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic              I_clk,
   input  logic              I_rst_n,
   mipi_lane_deskew_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] CFULL = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_ALL,
      S_STREAM,
      S_ERROR,
      S_DRAIN
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       lane_num_q;
   logic [TW-1:0]    tmr_q, tmr_d;
   logic             valid_q;
   logic [31:0]      data_q, data_d;
   logic             skew_q;
   logic             busy_q;

   logic [7:0]       mem_q    [4][FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr_q [4];
   logic [AW-1:0]    rd_ptr_q [4];
   logic [CW-1:0]    cnt_q    [4];

   logic [3:0]       act;
   logic [3:0]       ch_valid;
   logic [3:0][7:0]  ch_data;
   logic [3:0]       ne, full;
   logic [3:0]       wr_req, wr_en, pop_v;
   logic             all_ne, any_ne, accept;
   logic             pop_cand, pop, lane_err, ovf, err_evt;

   function automatic logic [3:0] lane_mask(input logic [1:0] num);
      case (num)
         2'd0:    lane_mask = 4'b0001;
         2'd1:    lane_mask = 4'b0011;
         default: lane_mask = 4'b1111;
      endcase
   endfunction

   assign ch_valid = {bus.I_ch3_valid, bus.I_ch2_valid, bus.I_ch1_valid, bus.I_ch0_valid};
   assign ch_data  = {bus.I_ch3_data, bus.I_ch2_data, bus.I_ch1_data, bus.I_ch0_data};

   // In IDLE the live lane count governs the first write; elsewhere the latched one does.
   assign act = lane_mask((state_q == S_IDLE) ? bus.I_lane_num : lane_num_q);

   always_comb begin
      ne   = '0;
      full = '0;
      for (int n = 0; n < 4; n++) begin
         ne[n]   = (cnt_q[n] != '0);
         full[n] = (cnt_q[n] == CFULL);
      end
   end

   assign all_ne   = ((ne & act) == act);
   assign any_ne   = |(ne & act);
   assign accept   = (state_q == S_IDLE) || (state_q == S_WAIT_ALL) || (state_q == S_STREAM);
   assign wr_req   = ch_valid & act & {4{accept}};
   assign pop_cand = (state_q == S_STREAM) && all_ne;
   assign lane_err = ((state_q == S_WAIT_ALL) || (state_q == S_STREAM)) && |(bus.I_lane_error & act);
   assign ovf      = |(wr_req & full & ~({4{pop_cand}} & act));
   assign pop      = pop_cand && !lane_err && !ovf;
   assign pop_v    = {4{pop}} & act;
   assign wr_en    = wr_req & (~full | pop_v) & {4{!err_evt}};

   always_comb begin
      data_d = '0;
      for (int n = 0; n < 4; n++) begin
         data_d[8*n +: 8] = act[n] ? mem_q[n][rd_ptr_q[n]] : 8'h00;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      err_evt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|wr_req) begin
               state_d = S_WAIT_ALL;
               tmr_d   = TMAX;
            end
         end
         S_WAIT_ALL: begin
            if (lane_err || ovf) begin
               err_evt = 1'b1;
            end else if (all_ne) begin
               state_d = S_STREAM;
               tmr_d   = TMAX;
            end else if (tmr_q == '0) begin
               err_evt = 1'b1;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_STREAM: begin
            if (lane_err || ovf) begin
               err_evt = 1'b1;
            end else if (pop_cand) begin
               tmr_d = TMAX;
            end else if (any_ne) begin
               if (tmr_q == '0) err_evt = 1'b1;
               else             tmr_d = tmr_q - TW'(1);
            end else if (!(|wr_req)) begin
               state_d = S_IDLE;
            end
         end
         S_ERROR: state_d = S_DRAIN;
         S_DRAIN: begin
            if (!(|(ch_valid & act))) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (err_evt) begin
         state_d = S_ERROR;
         tmr_d   = '0;
      end
   end

   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q    <= S_IDLE;
         lane_num_q <= 2'd3;
         tmr_q      <= '0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         skew_q     <= 1'b0;
         busy_q     <= 1'b0;
         for (int n = 0; n < 4; n++) begin
            cnt_q[n]    <= '0;
            wr_ptr_q[n] <= '0;
            rd_ptr_q[n] <= '0;
         end
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         valid_q <= pop;
         skew_q  <= err_evt;
         busy_q  <= (state_d != S_IDLE);
         if (state_q == S_IDLE) lane_num_q <= bus.I_lane_num;
         if (pop) data_q <= data_d;
         for (int n = 0; n < 4; n++) begin
            if (err_evt) begin
               cnt_q[n]    <= '0;
               wr_ptr_q[n] <= '0;
               rd_ptr_q[n] <= '0;
            end else begin
               if (wr_en[n]) wr_ptr_q[n] <= wr_ptr_q[n] + AW'(1);
               if (pop_v[n]) rd_ptr_q[n] <= rd_ptr_q[n] + AW'(1);
               cnt_q[n] <= cnt_q[n] + CW'(wr_en[n]) - CW'(pop_v[n]);
            end
         end
      end
   end

   always_ff @(posedge I_clk) begin
      for (int n = 0; n < 4; n++) begin
         if (wr_en[n]) mem_q[n][wr_ptr_q[n]] <= ch_data[n];
      end
   end

   assign bus.O_valid      = valid_q;
   assign bus.O_data       = data_q;
   assign bus.O_skew_error = skew_q;
   assign bus.O_busy       = busy_q;

endmodule

// File: tb/tb_mipi_lane_deskew.sv
// Scoreboard bench for the lane deskewer: expected words queued at stimulus, checked on O_valid.
module tb_mipi_lane_deskew;

   logic clk;
   logic rst_n;
   mipi_lane_deskew_if bus();

   mipi_lane_deskew #(.FIFO_DEPTH(8), .TIMEOUT(16)) dut (
      .I_clk   (clk),
      .I_rst_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc = cyc + 1;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] exp_q[$];
   int          valid_cnt, skew_cnt, first_valid, skew_cyc;
   logic [31:0] exp_w;

   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (bus.O_valid === 1'b1) begin
            valid_cnt++;
            if (first_valid < 0) first_valid = cyc;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL sb_extra: got O_data=%h at cycle %0d, required no word", bus.O_data, cyc);
            end else begin
               exp_w = exp_q.pop_front();
               if (bus.O_data !== exp_w) begin
                  n_bad++;
                  $display("FAIL sb_data: got O_data=%h at cycle %0d, required %h", bus.O_data, cyc, exp_w);
               end
            end
         end
         if (bus.O_skew_error === 1'b1) begin
            skew_cnt++;
            skew_cyc = cyc;
         end
      end
   end

   function automatic logic [7:0] bt(input int n, input int k);
      return 8'(8'h40 + 16 * n + k);
   endfunction

   function automatic logic [31:0] wordk(input int k);
      return {bt(3, k), bt(2, k), bt(1, k), bt(0, k)};
   endfunction

   task automatic clear_stats();
      valid_cnt   = 0;
      skew_cnt    = 0;
      first_valid = -1;
      skew_cyc    = -1;
   endtask

   task automatic idle_inputs();
      bus.I_ch0_valid  = 1'b0;
      bus.I_ch1_valid  = 1'b0;
      bus.I_ch2_valid  = 1'b0;
      bus.I_ch3_valid  = 1'b0;
      bus.I_ch0_data   = 8'h00;
      bus.I_ch1_data   = 8'h00;
      bus.I_ch2_data   = 8'h00;
      bus.I_ch3_data   = 8'h00;
      bus.I_lane_error = 4'h0;
   endtask

   // Present one beat and return 1 time unit after the edge that captured it.
   task automatic apply(input logic [3:0] v, input logic [31:0] d, input logic [3:0] err);
      bus.I_ch0_valid  = v[0];
      bus.I_ch1_valid  = v[1];
      bus.I_ch2_valid  = v[2];
      bus.I_ch3_valid  = v[3];
      bus.I_ch0_data   = d[7:0];
      bus.I_ch1_data   = d[15:8];
      bus.I_ch2_data   = d[23:16];
      bus.I_ch3_data   = d[31:24];
      bus.I_lane_error = err;
      @(posedge clk);
      #1;
   endtask

   task automatic settle(input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (bus.O_busy === 1'b0 && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
         apply(4'h0, 32'h0, 4'h0);
      end
      if (!ok) exp_q.delete();
      apply(4'h0, 32'h0, 4'h0);
   endtask

   task automatic test_reset();
      clear_stats();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.O_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b, required 0", bus.O_valid); end
      n_cmp++; if (bus.O_data !== 32'h0) begin n_bad++; $display("FAIL rst_data: got %h, required 00000000", bus.O_data); end
      n_cmp++; if (bus.O_skew_error !== 1'b0) begin n_bad++; $display("FAIL rst_skew: got %b, required 0", bus.O_skew_error); end
      n_cmp++; if (bus.O_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", bus.O_busy); end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      apply(4'h0, 32'h0, 4'hF);
      apply(4'h0, 32'h0, 4'hF);
      apply(4'h0, 32'h0, 4'h0);
      n_cmp++; if (skew_cnt !== 0) begin n_bad++; $display("FAIL idle_err_skew: got %0d pulses, required 0", skew_cnt); end
      n_cmp++; if (bus.O_busy !== 1'b0) begin n_bad++; $display("FAIL idle_err_busy: got %b, required 0", bus.O_busy); end
   endtask

   task automatic test_aligned();
      logic [31:0] d;
      int w0;
      bit ok;
      clear_stats();
      w0 = 0;
      bus.I_lane_num = 2'd3;
      for (int k = 0; k < 3; k++) begin
         for (int n = 0; n < 4; n++) d[8*n +: 8] = 8'(8'h10 + n + k);
         exp_q.push_back(d);
         apply(4'hF, d, 4'h0);
         if (k == 0) w0 = cyc;
      end
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL aligned_settle: got busy/pending, required idle"); end
      n_cmp++; if (valid_cnt != 3) begin n_bad++; $display("FAIL aligned_count: got %0d, required 3", valid_cnt); end
      n_cmp++; if (first_valid != w0 + 2) begin n_bad++; $display("FAIL aligned_latency: got cycle %0d, required %0d", first_valid, w0 + 2); end
      n_cmp++; if (skew_cnt != 0) begin n_bad++; $display("FAIL aligned_skew: got %0d, required 0", skew_cnt); end
   endtask

   task automatic test_skew();
      logic [31:0] d;
      logic [3:0]  v;
      int w3;
      bit ok;
      clear_stats();
      w3 = 0;
      for (int k = 0; k < 4; k++) exp_q.push_back(wordk(k));
      for (int c = 0; c < 7; c++) begin
         v = 4'h0;
         d = 32'h0;
         if (c < 4) begin
            for (int n = 0; n < 3; n++) begin
               v[n] = 1'b1;
               d[8*n +: 8] = bt(n, c);
            end
         end
         if (c >= 3) begin
            v[3] = 1'b1;
            d[31:24] = bt(3, c - 3);
         end
         apply(v, d, 4'h0);
         if (c == 3) w3 = cyc;
      end
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL skew_settle: got busy/pending, required idle"); end
      n_cmp++; if (valid_cnt != 4) begin n_bad++; $display("FAIL skew_count: got %0d, required 4", valid_cnt); end
      n_cmp++; if (first_valid != w3 + 2) begin n_bad++; $display("FAIL skew_latency: got cycle %0d, required %0d", first_valid, w3 + 2); end
      n_cmp++; if (skew_cnt != 0) begin n_bad++; $display("FAIL skew_err: got %0d, required 0", skew_cnt); end
   endtask

   task automatic test_timeout();
      int w0;
      bit ok;
      clear_stats();
      w0 = 0;
      for (int c = 0; c < 2; c++) begin
         apply(4'b1011, wordk(c), 4'h0);
         if (c == 0) w0 = cyc;
      end
      settle(40, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_settle: got busy, required idle"); end
      n_cmp++; if (skew_cnt != 1) begin n_bad++; $display("FAIL tmo_pulses: got %0d, required 1", skew_cnt); end
      n_cmp++; if (skew_cyc != w0 + 16) begin n_bad++; $display("FAIL tmo_time: got cycle %0d, required %0d", skew_cyc, w0 + 16); end
      n_cmp++; if (valid_cnt != 0) begin n_bad++; $display("FAIL tmo_valid: got %0d words, required 0", valid_cnt); end
   endtask

   task automatic test_two_lane();
      logic [3:0] v, err;
      bit ok;
      clear_stats();
      bus.I_lane_num = 2'd1;
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(32'h0000BBAA);
         v   = {c[0], ~c[0], 2'b11};
         err = {c[0], ~c[0], 2'b00};
         apply(v, 32'hDDCCBBAA, err);
         if (c == 0) bus.I_lane_num = 2'd3;
      end
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL two_settle: got busy/pending, required idle"); end
      n_cmp++; if (valid_cnt != 3) begin n_bad++; $display("FAIL two_count: got %0d, required 3", valid_cnt); end
      n_cmp++; if (skew_cnt != 0) begin n_bad++; $display("FAIL two_skew: got %0d, required 0", skew_cnt); end
      clear_stats();
      exp_q.push_back(wordk(5));
      apply(4'hF, wordk(5), 4'h0);
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL four_resume_settle: got busy/pending, required idle"); end
      n_cmp++; if (valid_cnt != 1) begin n_bad++; $display("FAIL four_resume_count: got %0d, required 1", valid_cnt); end
   endtask

   task automatic test_lane_error();
      int w0, w1;
      bit ok;
      clear_stats();
      w0 = 0;
      w1 = 0;
      exp_q.push_back(wordk(0));
      for (int c = 0; c < 6; c++) begin
         apply(4'hF, wordk(c), (c == 3) ? 4'b0010 : 4'b0000);
         if (c == 0) w0 = cyc;
      end
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL lerr_settle: got busy/pending, required idle"); end
      n_cmp++; if (skew_cnt != 1) begin n_bad++; $display("FAIL lerr_pulses: got %0d, required 1", skew_cnt); end
      n_cmp++; if (skew_cyc != w0 + 3) begin n_bad++; $display("FAIL lerr_time: got cycle %0d, required %0d", skew_cyc, w0 + 3); end
      n_cmp++; if (valid_cnt != 1) begin n_bad++; $display("FAIL lerr_words: got %0d, required 1", valid_cnt); end
      clear_stats();
      exp_q.push_back(wordk(9));
      apply(4'hF, wordk(9), 4'h0);
      w1 = cyc;
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL lerr_recover_settle: got busy/pending, required idle"); end
      n_cmp++; if (first_valid != w1 + 2) begin n_bad++; $display("FAIL lerr_recover_latency: got cycle %0d, required %0d", first_valid, w1 + 2); end
   endtask

   task automatic test_overflow();
      int w0;
      bit ok;
      clear_stats();
      w0 = 0;
      for (int c = 0; c < 12; c++) begin
         apply(4'b0111, wordk(c), 4'h0);
         if (c == 0) w0 = cyc;
      end
      n_cmp++; if (bus.O_busy !== 1'b1) begin n_bad++; $display("FAIL ovf_drain_busy: got %b, required 1", bus.O_busy); end
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL ovf_settle: got busy, required idle"); end
      n_cmp++; if (skew_cnt != 1) begin n_bad++; $display("FAIL ovf_pulses: got %0d, required 1", skew_cnt); end
      n_cmp++; if (skew_cyc != w0 + 8) begin n_bad++; $display("FAIL ovf_time: got cycle %0d, required %0d", skew_cyc, w0 + 8); end
      n_cmp++; if (valid_cnt != 0) begin n_bad++; $display("FAIL ovf_valid: got %0d words, required 0", valid_cnt); end
   endtask

   task automatic test_full_fifo();
      logic [31:0] d;
      logic [3:0]  v;
      int w0;
      bit ok;
      clear_stats();
      w0 = 0;
      for (int k = 0; k < 12; k++) exp_q.push_back(wordk(k));
      for (int c = 0; c < 21; c++) begin
         v = 4'h0;
         d = 32'h0;
         if (c <= 7 || (c >= 11 && c <= 14)) begin
            for (int n = 0; n < 3; n++) begin
               v[n] = 1'b1;
               d[8*n +: 8] = bt(n, (c <= 7) ? c : c - 3);
            end
         end
         if (c >= 9) begin
            v[3] = 1'b1;
            d[31:24] = bt(3, c - 9);
         end
         apply(v, d, 4'h0);
         if (c == 0) w0 = cyc;
      end
      settle(40, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL full_settle: got busy/pending, required idle"); end
      n_cmp++; if (valid_cnt != 12) begin n_bad++; $display("FAIL full_count: got %0d, required 12", valid_cnt); end
      n_cmp++; if (first_valid != w0 + 11) begin n_bad++; $display("FAIL full_latency: got cycle %0d, required %0d", first_valid, w0 + 11); end
      n_cmp++; if (skew_cnt != 0) begin n_bad++; $display("FAIL full_skew: got %0d, required 0", skew_cnt); end
   endtask

   task automatic test_mid_reset();
      bit ok;
      clear_stats();
      apply(4'b0111, wordk(0), 4'h0);
      apply(4'b0111, wordk(1), 4'h0);
      idle_inputs();
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.O_busy !== 1'b0) begin n_bad++; $display("FAIL mrst_busy: got %b, required 0", bus.O_busy); end
      n_cmp++; if (bus.O_valid !== 1'b0) begin n_bad++; $display("FAIL mrst_valid: got %b, required 0", bus.O_valid); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      repeat (4) apply(4'h0, 32'h0, 4'h0);
      n_cmp++; if (valid_cnt != 0) begin n_bad++; $display("FAIL mrst_stale: got %0d words, required 0", valid_cnt); end
      exp_q.push_back(wordk(7));
      apply(4'hF, wordk(7), 4'h0);
      settle(30, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL mrst_settle: got busy/pending, required idle"); end
      n_cmp++; if (valid_cnt != 1) begin n_bad++; $display("FAIL mrst_count: got %0d, required 1", valid_cnt); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      bus.I_lane_num = 2'd3;
      idle_inputs();
      clear_stats();
      test_reset();
      test_aligned();
      test_skew();
      test_timeout();
      test_two_lane();
      test_lane_error();
      test_overflow();
      test_full_fifo();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
